sync_filter: RTL and testbench
==============================

SYNC_FILTER -- requirements
Module: sync_filter

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent input channels (1..32).
REQ-002 SHALL have parameter STAGES, default 2, synchronizer flip-flops per channel (2..4).
REQ-003 SHALL have parameter RST_VAL, default all ones (NUM_CH bits), per-channel reset/inactive value.
REQ-004 SHALL have parameter FILT_CYCLES, default 3, consecutive stable cycles required before the filtered output changes (1..15).
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port n_rst  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port async_in  input  NUM_CH  asynchronous channel inputs.
REQ-008 SHALL have port sync_out  output  NUM_CH  raw synchronized value (last chain stage).
REQ-009 SHALL have port filt_out  output  NUM_CH  debounced value.
REQ-010 SHALL have port rise  output  NUM_CH  one-cycle pulse on filt_out 0->1.
REQ-011 SHALL have port fall  output  NUM_CH  one-cycle pulse on filt_out 1->0.
REQ-012 SHALL have port any_edge  output  1  OR of all rise and fall bits.

Function
REQ-013 Each channel SHALL pass async_in through STAGES cascaded flops; sync_out is the last stage; async_in meeting setup appears on sync_out after exactly STAGES rising edges.
REQ-014 Each channel SHALL hold a counter of width clog2(FILT_CYCLES+1), cleared on any cycle where sync_out equals filt_out.
REQ-015 While sync_out differs from filt_out, the counter SHALL increment each cycle; on the edge where it would reach FILT_CYCLES, filt_out takes sync_out and the counter clears.
REQ-016 Clean input change SHALL reach filt_out after exactly STAGES+FILT_CYCLES rising edges.
REQ-017 A sync_out excursion shorter than FILT_CYCLES cycles SHALL leave filt_out unchanged and produce no pulse; the counter restarts from 0 on the next excursion.
REQ-018 rise/fall SHALL be registered, asserted in the same cycle filt_out changes, high exactly one cycle.
REQ-019 Channels SHALL be fully independent; simultaneous changes on several channels produce simultaneous pulses.
REQ-020 any_edge SHALL be combinational OR of rise and fall, no extra latency.
REQ-021 Counter SHALL never exceed FILT_CYCLES and never wrap.

Reset
REQ-022 On n_rst low, immediately and without clock: all chain stages, sync_out, filt_out = RST_VAL; counters = 0; rise = fall = 0; any_edge = 0.
REQ-023 Reset asserted mid-count SHALL discard the count; no pulse emitted during or on release of reset.
REQ-024 After release, an input already differing from RST_VAL SHALL incur full STAGES+FILT_CYCLES latency.

Structure
REQ-025 Package sync_pkg SHALL hold MAX_STAGES (4), MAX_FILT (15) and the counter-width constant function.
REQ-026 Per-channel logic SHALL be sub-module sync_filter_ch (chain, counter, edge regs), generated NUM_CH times; top adds only any_edge and parameter range checks (elaboration error if out of range).

Verification (NUM_CH=4, STAGES=2, FILT_CYCLES=3, RST_VAL=4'b1111, 1 ns clock, stimulus at negedge)
REQ-027 Reset: n_rst low between edges -> sync_out=filt_out=4'b1111, rise=fall=0 within 0.1 ns, held over two clocks.
REQ-028 async_in[0] 1->0 held -> sync_out[0]=0 after 2nd posedge; filt_out[0]=0 and fall[0]=1 after 5th posedge, fall[0]=0 after 6th.
REQ-029 Glitch: async_in[1] low for 2 cycles -> sync_out[1] low 2 cycles; filt_out[1] stays 1, no fall, any_edge stays 0.
REQ-030 async_in[3:2] 11->00 same negedge -> fall=4'b1100 and any_edge=1 for exactly one cycle after 5th posedge.
REQ-031 async_in[0] low 4 cycles then n_rst pulsed low -> no fall pulse, filt_out[0]=1; after release with input still 0, fall[0] exactly 5 posedges later.
REQ-032 Instance STAGES=3, FILT_CYCLES=1, RST_VAL=4'b0000: async_in[2] 0->1 -> filt_out[2]=1 and rise[2]=1 after 4th posedge, one cycle.

Source files
------------

// File: rtl/sync_filter_pkg.sv
// -----------------------------------------------------------------------------
// sync_pkg
// Shared constants and helpers for the sync_filter block.
//   MAX_STAGES : deepest synchronizer chain supported per channel
//   MAX_FILT   : largest debounce length supported
//   cnt_width  : width of a counter that must be able to hold 0..filt_cycles
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package sync_pkg;

    localparam int MIN_CH     = 1;
    localparam int MAX_CH     = 32;
    localparam int MIN_STAGES = 2;
    localparam int MAX_STAGES = 4;
    localparam int MIN_FILT   = 1;
    localparam int MAX_FILT   = 15;

    // Counter width for a debounce length; always at least one bit because
    // filt_cycles is at least 1.
    function automatic int cnt_width(input int filt_cycles);
        return $clog2(filt_cycles + 1);
    endfunction

endpackage

// File: rtl/sync_filter_ch.sv
// -----------------------------------------------------------------------------
// sync_filter_ch
// One channel of the synchronizer / debounce filter.
//   clk      : single clock, rising edge
//   n_rst    : asynchronous active-low reset
//   async_in : raw asynchronous input
//   sync_out : last synchronizer stage
//   filt_out : debounced value
//   rise     : one-cycle pulse when filt_out goes 0->1
//   fall     : one-cycle pulse when filt_out goes 1->0
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module sync_filter_ch
    import sync_pkg::*;
#(
    parameter int   STAGES      = 2,
    parameter int   FILT_CYCLES = 3,
    parameter logic RST_VAL     = 1'b1
) (
    input  logic clk,
    input  logic n_rst,
    input  logic async_in,
    output logic sync_out,
    output logic filt_out,
    output logic rise,
    output logic fall
);

    localparam int CW = cnt_width(FILT_CYCLES);

    logic [STAGES-1:0] chain;
    logic [CW-1:0]     cnt;
    logic              filt_q;
    logic              rise_q;
    logic              fall_q;
    logic              diff;
    logic              fire;

    // A change is only accepted once sync_out has disagreed with filt_out for
    // FILT_CYCLES consecutive edges; the edge that would bring the counter to
    // FILT_CYCLES is the one that commits, so the counter never holds that
    // value and can never wrap.
    assign diff = chain[STAGES-1] ^ filt_q;
    assign fire = diff && (cnt == CW'(FILT_CYCLES - 1));

    // Synchronizer chain; bit 0 is the metastability-catching stage.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            chain <= {STAGES{RST_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], async_in};
        end
    end

    // Debounce counter, filtered value and registered edge pulses.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt    <= '0;
            filt_q <= RST_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= fire &  chain[STAGES-1];
            fall_q <= fire & ~chain[STAGES-1];
            if (!diff) begin
                cnt <= '0;
            end else if (fire) begin
                filt_q <= chain[STAGES-1];
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign sync_out = chain[STAGES-1];
    assign filt_out = filt_q;
    assign rise     = rise_q;
    assign fall     = fall_q;

endmodule

// File: rtl/sync_filter.sv
// -----------------------------------------------------------------------------
// sync_filter
// Multi-channel input synchronizer with per-channel debounce and edge pulses.
//   clk      : single clock, rising edge
//   n_rst    : asynchronous active-low reset
//   async_in : [NUM_CH] asynchronous inputs
//   sync_out : [NUM_CH] raw synchronized values
//   filt_out : [NUM_CH] debounced values
//   rise     : [NUM_CH] one-cycle pulse on filt_out 0->1
//   fall     : [NUM_CH] one-cycle pulse on filt_out 1->0
//   any_edge : OR of every rise and fall bit (combinational)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module sync_filter
    import sync_pkg::*;
#(
    parameter int                NUM_CH      = 4,
    parameter int                STAGES      = 2,
    parameter logic [NUM_CH-1:0] RST_VAL     = '1,
    parameter int                FILT_CYCLES = 3
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [NUM_CH-1:0] async_in,
    output logic [NUM_CH-1:0] sync_out,
    output logic [NUM_CH-1:0] filt_out,
    output logic [NUM_CH-1:0] rise,
    output logic [NUM_CH-1:0] fall,
    output logic              any_edge
);

    // Out-of-range parameters stop elaboration rather than building a
    // silently broken filter.
    if (NUM_CH < MIN_CH || NUM_CH > MAX_CH) begin : g_bad_num_ch
        $error("sync_filter: NUM_CH=%0d out of range %0d..%0d", NUM_CH, MIN_CH, MAX_CH);
    end
    if (STAGES < MIN_STAGES || STAGES > MAX_STAGES) begin : g_bad_stages
        $error("sync_filter: STAGES=%0d out of range %0d..%0d", STAGES, MIN_STAGES, MAX_STAGES);
    end
    if (FILT_CYCLES < MIN_FILT || FILT_CYCLES > MAX_FILT) begin : g_bad_filt
        $error("sync_filter: FILT_CYCLES=%0d out of range %0d..%0d", FILT_CYCLES, MIN_FILT, MAX_FILT);
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        sync_filter_ch #(
            .STAGES      (STAGES),
            .FILT_CYCLES (FILT_CYCLES),
            .RST_VAL     (RST_VAL[i])
        ) u_ch (
            .clk      (clk),
            .n_rst    (n_rst),
            .async_in (async_in[i]),
            .sync_out (sync_out[i]),
            .filt_out (filt_out[i]),
            .rise     (rise[i]),
            .fall     (fall[i])
        );
    end

    assign any_edge = |{rise, fall};

endmodule

// File: tb/tb_sync_filter.sv
// -----------------------------------------------------------------------------
// tb_sync_filter
// Directed bench for sync_filter: default instance (4 ch, 2 stages, 3-cycle
// filter, reset value 1111) plus a second instance (3 stages, 1-cycle filter,
// reset value 0000). Inputs change on the falling edge; outputs are sampled
// 0.2 ns after the rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_sync_filter;

    logic       tb_clk;
    logic       n_rst;
    logic [3:0] async_a;
    logic [3:0] sync_a, filt_a, rise_a, fall_a;
    logic       any_a;
    logic [3:0] async_b;
    logic [3:0] sync_b, filt_b, rise_b, fall_b;
    logic       any_b;

    int total_checks = 0;
    int pass_checks  = 0;

    sync_filter #(
        .NUM_CH      (4),
        .STAGES      (2),
        .RST_VAL     (4'b1111),
        .FILT_CYCLES (3)
    ) dut_a (
        .clk      (tb_clk),
        .n_rst    (n_rst),
        .async_in (async_a),
        .sync_out (sync_a),
        .filt_out (filt_a),
        .rise     (rise_a),
        .fall     (fall_a),
        .any_edge (any_a)
    );

    sync_filter #(
        .NUM_CH      (4),
        .STAGES      (3),
        .RST_VAL     (4'b0000),
        .FILT_CYCLES (1)
    ) dut_b (
        .clk      (tb_clk),
        .n_rst    (n_rst),
        .async_in (async_b),
        .sync_out (sync_b),
        .filt_out (filt_b),
        .rise     (rise_b),
        .fall     (fall_b),
        .any_edge (any_b)
    );

    // 1 ns clock
    initial begin
        tb_clk = 1'b0;
        forever #0.5 tb_clk = ~tb_clk;
    end

    task automatic check_output(input string tag, input logic [31:0] actual,
                                input logic [31:0] expected);
        total_checks++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, actual, expected, $time);
        end else begin
            pass_checks++;
        end
    endtask

    // Wait for the next rising edge and step to the sampling point.
    task automatic next_sample();
        @(posedge tb_clk);
        #0.2;
    endtask

    task automatic apply_stimulus(input logic [3:0] a_val, input logic [3:0] b_val);
        @(negedge tb_clk);
        async_a = a_val;
        async_b = b_val;
    endtask

    initial begin
        n_rst   = 1'b1;
        async_a = 4'b1111;
        async_b = 4'b0000;

        // Reset asserted between edges takes effect without a clock.
        #0.25;
        n_rst = 1'b0;
        #0.1;
        check_output("rst_sync_now", 32'(sync_a), 32'h0000000F);
        check_output("rst_filt_now", 32'(filt_a), 32'h0000000F);
        check_output("rst_rise_now", 32'(rise_a), 32'h0);
        check_output("rst_fall_now", 32'(fall_a), 32'h0);
        check_output("rst_any_now",  32'(any_a),  32'h0);
        check_output("rst_filt_b",   32'(filt_b), 32'h0);
        next_sample();
        next_sample();
        check_output("rst_sync_hold", 32'(sync_a), 32'h0000000F);
        check_output("rst_filt_hold", 32'(filt_a), 32'h0000000F);
        check_output("rst_edge_hold", 32'({rise_a, fall_a}), 32'h0);
        @(negedge tb_clk);
        n_rst = 1'b1;
        repeat (3) next_sample();

        // Channel 0 falls cleanly: sync after 2 edges, filt and fall after 5.
        apply_stimulus(4'b1110, 4'b0000);
        for (int c = 1; c <= 6; c++) begin
            next_sample();
            check_output($sformatf("ch0_sync_c%0d", c), 32'(sync_a[0]), (c >= 2) ? 32'h0 : 32'h1);
            check_output($sformatf("ch0_filt_c%0d", c), 32'(filt_a[0]), (c >= 5) ? 32'h0 : 32'h1);
            check_output($sformatf("ch0_fall_c%0d", c), 32'(fall_a), (c == 5) ? 32'h1 : 32'h0);
            check_output($sformatf("ch0_any_c%0d", c),  32'(any_a),  (c == 5) ? 32'h1 : 32'h0);
        end

        // Channel 1 glitches low for two cycles; the filter must reject it.
        apply_stimulus(4'b1100, 4'b0000);
        for (int c = 1; c <= 8; c++) begin
            next_sample();
            check_output($sformatf("gl_sync1_c%0d", c), 32'(sync_a[1]), (c == 2 || c == 3) ? 32'h0 : 32'h1);
            check_output($sformatf("gl_filt1_c%0d", c), 32'(filt_a[1]), 32'h1);
            check_output($sformatf("gl_fall_c%0d", c),  32'(fall_a), 32'h0);
            check_output($sformatf("gl_any_c%0d", c),   32'(any_a),  32'h0);
            if (c == 2) begin
                @(negedge tb_clk);
                async_a[1] = 1'b1;
            end
        end

        // Channels 3 and 2 fall together and pulse together.
        apply_stimulus(4'b0010, 4'b0000);
        for (int c = 1; c <= 6; c++) begin
            next_sample();
            check_output($sformatf("ch32_fall_c%0d", c), 32'(fall_a), (c == 5) ? 32'hC : 32'h0);
            check_output($sformatf("ch32_any_c%0d", c),  32'(any_a),  (c == 5) ? 32'h1 : 32'h0);
            check_output($sformatf("ch32_filt_c%0d", c), 32'(filt_a), (c >= 5) ? 32'h2 : 32'hE);
        end

        // Bring everything back high: channels 0, 2, 3 rise together.
        apply_stimulus(4'b1111, 4'b0000);
        for (int c = 1; c <= 6; c++) begin
            next_sample();
            check_output($sformatf("back_rise_c%0d", c), 32'(rise_a), (c == 5) ? 32'hD : 32'h0);
        end
        check_output("back_filt", 32'(filt_a), 32'hF);

        // Channel 0 counting when reset hits: count discarded, no pulse.
        apply_stimulus(4'b1110, 4'b0000);
        repeat (4) next_sample();
        check_output("mid_filt_pre", 32'(filt_a[0]), 32'h1);
        @(negedge tb_clk);
        n_rst = 1'b0;
        #0.1;
        check_output("mid_rst_sync", 32'(sync_a), 32'hF);
        check_output("mid_rst_fall", 32'(fall_a), 32'h0);
        next_sample();
        check_output("mid_rst_filt", 32'(filt_a[0]), 32'h1);
        check_output("mid_rst_any",  32'(any_a),     32'h0);
        @(negedge tb_clk);
        n_rst = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            next_sample();
            check_output($sformatf("rel_fall_c%0d", c), 32'(fall_a), (c == 5) ? 32'h1 : 32'h0);
            check_output($sformatf("rel_filt_c%0d", c), 32'(filt_a[0]), (c >= 5) ? 32'h0 : 32'h1);
        end

        // Second instance: 3 stages + 1 filter cycle -> rise after 4 edges.
        apply_stimulus(4'b1110, 4'b0100);
        for (int c = 1; c <= 5; c++) begin
            next_sample();
            check_output($sformatf("b_sync_c%0d", c), 32'(sync_b), (c >= 3) ? 32'h4 : 32'h0);
            check_output($sformatf("b_filt_c%0d", c), 32'(filt_b), (c >= 4) ? 32'h4 : 32'h0);
            check_output($sformatf("b_rise_c%0d", c), 32'(rise_b), (c == 4) ? 32'h4 : 32'h0);
            check_output($sformatf("b_any_c%0d", c),  32'(any_b),  (c == 4) ? 32'h1 : 32'h0);
        end

        $display("%0d/%0d checks passed", pass_checks, total_checks);
        $finish;
    end

endmodule
